// File: rtl/rr_prio_arbiter.sv
// rr_prio_arbiter
// Eight-way round-robin arbiter with a rotating-priority search, registered
// one-hot grant plus binary index, grant locking while the owner keeps its
// request, and a maximum-hold limit that forces rotation when others wait.
// Downstream logic uses gnt_id as a mux select, so every output is a flop.

module rr_prio_arbiter #(
    parameter int N        = 8,
    parameter int IDW      = 3,
    parameter int MAX_HOLD = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           gnt_valid,
    output logic           preempt
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Hold limit expressed in the counter's own width; zero disables the limit.
    localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);
    localparam logic [3:0] HOLD_SAT_C = 4'd15;

    // Rotating-priority search: first set bit of r at start, start+1, ...
    // wrapping modulo N. Returns {found, index}.
    function automatic logic [IDW:0] find_winner(input logic [N-1:0]   r,
                                                 input logic [IDW-1:0] start);
        logic           found;
        logic [IDW-1:0] idx;
        logic [IDW-1:0] k;
        found = 1'b0;
        idx   = {IDW{1'b0}};
        for (int i = 0; i < N; i++) begin
            k = start + IDW'(i);
            if (!found && r[k]) begin
                found = 1'b1;
                idx   = k;
            end else begin
                idx   = idx;
            end
        end
        return {found, idx};
    endfunction

    // Binary index to one-hot vector.
    function automatic logic [N-1:0] to_onehot(input logic [IDW-1:0] idx);
        logic [N-1:0] v;
        v      = {N{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

    // Registered state
    state_t         state_r;
    logic [IDW-1:0] ptr_r;
    logic [IDW-1:0] owner_r;
    logic [3:0]     hold_cnt_r;
    logic [N-1:0]   gnt_r;
    logic [IDW-1:0] gnt_id_r;
    logic           gnt_valid_r;
    logic           preempt_r;

    // Next-state values
    state_t         state_s;
    logic [IDW-1:0] ptr_s;
    logic [IDW-1:0] owner_s;
    logic [3:0]     hold_cnt_s;
    logic [N-1:0]   gnt_s;
    logic [IDW-1:0] gnt_id_s;
    logic           gnt_valid_s;
    logic           preempt_s;

    // Helper terms
    logic [IDW-1:0] next_start_s;
    logic [N-1:0]   others_s;
    logic [IDW:0]   win_ptr_s;
    logic [IDW:0]   win_next_s;
    logic           hold_expired_s;

    // Search candidates: from the rotating pointer (idle) and from the
    // position after the owner, owner masked out (release / rotation).
    always_comb begin
        next_start_s   = owner_r + 3'd1;
        others_s       = req & ~to_onehot(owner_r);
        win_ptr_s      = find_winner(req, ptr_r);
        win_next_s     = find_winner(others_s, next_start_s);
        hold_expired_s = (MAX_HOLD_C != 4'd0) && (hold_cnt_r == MAX_HOLD_C);
    end

    // Next-state and next-output logic; rules in GRANT are evaluated in
    // priority order: disable, release, forced rotation, keep.
    always_comb begin
        state_s     = state_r;
        ptr_s       = ptr_r;
        owner_s     = owner_r;
        hold_cnt_s  = hold_cnt_r;
        gnt_s       = gnt_r;
        gnt_id_s    = gnt_id_r;
        gnt_valid_s = gnt_valid_r;
        preempt_s   = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (en && (req != {N{1'b0}})) begin
                    state_s     = ST_GRANT;
                    owner_s     = win_ptr_s[IDW-1:0];
                    hold_cnt_s  = 4'd1;
                    gnt_s       = to_onehot(win_ptr_s[IDW-1:0]);
                    gnt_id_s    = win_ptr_s[IDW-1:0];
                    gnt_valid_s = 1'b1;
                end else begin
                    state_s     = ST_IDLE;
                    gnt_s       = {N{1'b0}};
                    gnt_id_s    = {IDW{1'b0}};
                    gnt_valid_s = 1'b0;
                end
            end

            ST_GRANT: begin
                if (!en) begin
                    // Forced release; the pointer is kept so arbitration
                    // resumes where it left off.
                    state_s     = ST_IDLE;
                    gnt_s       = {N{1'b0}};
                    gnt_id_s    = {IDW{1'b0}};
                    gnt_valid_s = 1'b0;
                end else if (!req[owner_r]) begin
                    // Owner released: hand over back-to-back if anyone waits.
                    ptr_s = next_start_s;
                    if (win_next_s[IDW]) begin
                        owner_s     = win_next_s[IDW-1:0];
                        hold_cnt_s  = 4'd1;
                        gnt_s       = to_onehot(win_next_s[IDW-1:0]);
                        gnt_id_s    = win_next_s[IDW-1:0];
                        gnt_valid_s = 1'b1;
                    end else begin
                        state_s     = ST_IDLE;
                        gnt_s       = {N{1'b0}};
                        gnt_id_s    = {IDW{1'b0}};
                        gnt_valid_s = 1'b0;
                    end
                end else if (hold_expired_s && win_next_s[IDW]) begin
                    // Hold limit reached with competitors waiting: rotate.
                    ptr_s       = next_start_s;
                    owner_s     = win_next_s[IDW-1:0];
                    hold_cnt_s  = 4'd1;
                    gnt_s       = to_onehot(win_next_s[IDW-1:0]);
                    gnt_id_s    = win_next_s[IDW-1:0];
                    gnt_valid_s = 1'b1;
                    preempt_s   = 1'b1;
                end else begin
                    // Keep the grant; count saturates so a lone owner never wraps.
                    if (hold_cnt_r != HOLD_SAT_C) begin
                        hold_cnt_s = hold_cnt_r + 4'd1;
                    end else begin
                        hold_cnt_s = hold_cnt_r;
                    end
                end
            end

            default: begin
                state_s     = ST_IDLE;
                gnt_s       = {N{1'b0}};
                gnt_id_s    = {IDW{1'b0}};
                gnt_valid_s = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            ptr_r       <= {IDW{1'b0}};
            owner_r     <= {IDW{1'b0}};
            hold_cnt_r  <= 4'd0;
            gnt_r       <= {N{1'b0}};
            gnt_id_r    <= {IDW{1'b0}};
            gnt_valid_r <= 1'b0;
            preempt_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            ptr_r       <= ptr_s;
            owner_r     <= owner_s;
            hold_cnt_r  <= hold_cnt_s;
            gnt_r       <= gnt_s;
            gnt_id_r    <= gnt_id_s;
            gnt_valid_r <= gnt_valid_s;
            preempt_r   <= preempt_s;
        end
    end

    assign gnt       = gnt_r;
    assign gnt_id    = gnt_id_r;
    assign gnt_valid = gnt_valid_r;
    assign preempt   = preempt_r;

endmodule
